// File: rtl/sfifo_pkg.sv
// Shared types, width helper and elaboration-time parameter checks for the sync FIFO family.
package sfifo_pkg;

  typedef enum logic {ST_EMPTY, ST_ACTIVE} state_t;

  // Counter/pointer width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`ifndef SFIFO_PKG_CHECKS
`define SFIFO_PKG_CHECKS
`define SFIFO_CHECK_WIDTHS(iw, ow) \
  if ((((iw) % (ow)) != 0) || (((iw) / (ow)) < 1) || (((iw) / (ow)) > 16)) begin : g_bad_widths \
    $error("sfifo: IW must be a multiple of OW with IW/OW in 1..16"); \
  end
`define SFIFO_CHECK_DEPTH(d) \
  if ((d) < 1) begin : g_bad_depth \
    $error("sfifo: depth must be at least 1"); \
  end
`endif

// File: rtl/sync_fifo.sv
// Generic show-ahead synchronous FIFO; write visible at the head one cycle later.
// Writes ignored when full; underflow is a sticky flag raised by a pop while empty.
module sync_fifo
  import sfifo_pkg::*;
#(
  parameter int W = 32,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         full,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         underflow
);

  localparam int AW   = clog2_min1(D);
  localparam int CNTW = clog2_min1(D + 1);

  `SFIFO_CHECK_DEPTH(D)

  logic [W-1:0]    mem [D];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            do_wr, do_rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(D - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CNTW'(D));
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/sfifo_rd_unpack.sv
// Pops IW-bit FIFO words and emits IW/OW narrow beats on valid/ready; first beat one cycle after pop, 1 beat/clk.
// Holds beats stable under backpressure; LSB slice first unless SFIFO_RD_UNPACK_MSB_FIRST_EN is defined.
module sfifo_rd_unpack
  import sfifo_pkg::*;
#(
  parameter int IW = 32,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          fifo_empty,
  input  logic [IW-1:0] fifo_rd_data,
  output logic          fifo_rd_en,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] m_data,
  output logic          m_last,
  output logic          busy
);

  localparam int RATIO = IW / OW;
  localparam int CW    = clog2_min1(RATIO);
  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

  `SFIFO_CHECK_WIDTHS(IW, OW)

  state_t        state_q, state_d;
  logic [IW-1:0] hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_vld, accept;

  assign hold_vld = (state_q == ST_ACTIVE);
  assign m_valid  = hold_vld;
  assign busy     = hold_vld;
  assign m_last   = hold_vld & (cnt_q == CNT_LAST);
  assign accept   = hold_vld & m_ready;

  // Refill on the last-beat accept keeps consecutive words bubble-free.
  assign fifo_rd_en = reset_n & ~fifo_empty & ~flush & (~hold_vld | (accept & m_last));

  always_comb begin
    m_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt_q == CW'(i)) begin
`ifdef SFIFO_RD_UNPACK_MSB_FIRST_EN
        m_data = hold_q[(RATIO-1-i)*OW +: OW];
`else
        m_data = hold_q[i*OW +: OW];
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_EMPTY;
      cnt_d   = '0;
    end else if (fifo_rd_en) begin
      state_d = ST_ACTIVE;
      hold_d  = fifo_rd_data;
      cnt_d   = '0;
    end else if (accept) begin
      if (m_last) begin
        state_d = ST_EMPTY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sfifo_rd_unpack.sv
// Bench: sfifo_rd_unpack fed by sync_fifo (D=4); beat-queue scoreboard plus directed literal checks.
module tb_sfifo_rd_unpack;

  localparam int IW    = 32;
  localparam int OW    = 8;
  localparam int RATIO = IW / OW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          flush = 1'b0;
  logic          m_ready = 1'b0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_data = '0;
  logic          f_full, fifo_empty, fifo_rd_en, underflow;
  logic [IW-1:0] fifo_rd_data;
  logic          m_valid, m_last, busy;
  logic [OW-1:0] m_data;

  sync_fifo #(.W(IW), .D(4)) u_fifo (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .full(f_full),
    .rd_en(fifo_rd_en), .rd_data(fifo_rd_data), .empty(fifo_empty), .underflow(underflow)
  );

  sfifo_rd_unpack #(.IW(IW), .OW(OW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef SFIFO_RD_UNPACK_MSB_FIRST_EN
  localparam logic [7:0] E1 [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
  localparam logic [7:0] E2 [8] = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h01, 8'h02, 8'h03, 8'h04};
  localparam logic [7:0] E5 [4] = '{8'h88, 8'h77, 8'h66, 8'h55};
`else
  localparam logic [7:0] E1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  localparam logic [7:0] E2 [8] = '{8'hD0, 8'hC0, 8'hB0, 8'hA0, 8'h04, 8'h03, 8'h02, 8'h01};
  localparam logic [7:0] E5 [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
`endif

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model: the beat stream is just each pushed word cut into RATIO slices in emission order.
  function automatic logic [OW-1:0] beat_of(input logic [IW-1:0] w, input int k);
`ifdef SFIFO_RD_UNPACK_MSB_FIRST_EN
    return OW'(w >> (OW * (RATIO - 1 - k)));
`else
    return OW'(w >> (OW * k));
`endif
  endfunction

  typedef struct packed {logic [OW-1:0] d; logic l;} beat_t;
  beat_t         exp_q[$];
  int            acc_cyc[$];
  logic [OW-1:0] acc_dat[$];
  logic          acc_last[$];
  int            pop_cyc[$];
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_dat;
  logic          prev_last;

  always @(negedge clk) begin
    beat_t b;
    if (!reset_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("fifo_underflow", underflow, 0);
      chk("busy_tracks_valid", busy, m_valid);
      if (fifo_rd_en) begin
        chk("pop_while_empty", fifo_empty, 0);
        chk("pop_during_flush", flush, 0);
        pop_cyc.push_back(cyc);
      end
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_dat);
        chk("stall_last", m_last, prev_last);
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_beat actual=0x%0h required=no beat (cycle %0d)", m_data, cyc);
        end else begin
          chk("beat_data", m_data, exp_q[0].d);
          chk("beat_last", m_last, exp_q[0].l);
        end
      end else begin
        chk("idle_last", m_last, 0);
      end
      if (flush) begin
        if (m_valid) begin
          while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            if (b.l) break;
          end
        end
      end else if (m_valid && m_ready) begin
        acc_cyc.push_back(cyc);
        acc_dat.push_back(m_data);
        acc_last.push_back(m_last);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      prev_stall = m_valid && !m_ready && !flush;
      prev_dat   = m_data;
      prev_last  = m_last;
      if (wr_en && !f_full) begin
        for (int k = 0; k < RATIO; k++) exp_q.push_back({beat_of(wr_data, k), (k == RATIO - 1)});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IW-1:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic clear_logs();
    acc_cyc.delete();
    acc_dat.delete();
    acc_last.delete();
    pop_cyc.delete();
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!m_valid && n < budget) begin
      step();
      n++;
    end
    if (!m_valid) chk({name, "_timeout"}, m_valid, 1);
  endtask

  task automatic run_basic(input string tag);
    clear_logs();
    m_ready = 1'b1;
    push(32'h44332211);
    repeat (8) step();
    chk({tag, "_beat_count"}, acc_dat.size(), 4);
    chk({tag, "_pop_count"}, pop_cyc.size(), 1);
    if (acc_dat.size() == 4 && pop_cyc.size() == 1) begin
      chk({tag, "_latency"}, acc_cyc[0], pop_cyc[0] + 1);
      for (int i = 0; i < 4; i++) begin
        chk({tag, "_data"}, acc_dat[i], E1[i]);
        chk({tag, "_last"}, acc_last[i], (i == 3));
        chk({tag, "_consecutive"}, acc_cyc[i], acc_cyc[0] + i);
      end
    end
  endtask

  initial begin
    int flush_cyc;
    #1 reset_n = 1'b0;
    repeat (2) step();
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", m_data, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    reset_n = 1'b1;
    step();

    run_basic("basic");

    // Two words back to back: refill must coincide with the last beat of the first word.
    clear_logs();
    push(32'hA0B0C0D0);
    push(32'h01020304);
    repeat (12) step();
    chk("b2b_beat_count", acc_dat.size(), 8);
    chk("b2b_pop_count", pop_cyc.size(), 2);
    if (acc_dat.size() == 8 && pop_cyc.size() == 2) begin
      chk("b2b_second_pop", pop_cyc[1], acc_cyc[3]);
      for (int i = 0; i < 8; i++) begin
        chk("b2b_data", acc_dat[i], E2[i]);
        chk("b2b_last", acc_last[i], (i == 3 || i == 7));
        chk("b2b_consecutive", acc_cyc[i], acc_cyc[0] + i);
      end
    end

    // Backpressure pattern 1,0,0,1.
    clear_logs();
    m_ready = 1'b0;
    push(32'h44332211);
    for (int i = 0; i < 20; i++) begin
      m_ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    chk("bp_beat_count", acc_dat.size(), 4);
    chk("bp_pop_count", pop_cyc.size(), 1);
    if (acc_dat.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("bp_data", acc_dat[i], E1[i]);
    end

    // FIFO empty, random ready.
    clear_logs();
    for (int i = 0; i < 20; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
      chk("empty_valid", m_valid, 0);
    end
    chk("empty_pops", pop_cyc.size(), 0);
    chk("empty_beats", acc_dat.size(), 0);

    // Flush after two beats with a second word queued.
    m_ready = 1'b0;
    push(32'h44332211);
    push(32'h88776655);
    wait_valid("flush_first", 10);
    m_ready = 1'b1;
    step();
    step();
    m_ready   = 1'b0;
    flush     = 1'b1;
    flush_cyc = cyc;
    clear_logs();
    step();
    flush = 1'b0;
    chk("flush_drops_valid", m_valid, 0);
    m_ready = 1'b1;
    repeat (8) step();
    chk("flush_pop_count", pop_cyc.size(), 1);
    if (pop_cyc.size() == 1) chk("flush_pop_cycle", pop_cyc[0], flush_cyc + 1);
    chk("flush_beat_count", acc_dat.size(), 4);
    if (acc_dat.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("flush_data", acc_dat[i], E5[i]);
    end

    // Asynchronous reset in the middle of a word.
    push(32'h44332211);
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_last", m_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", m_data, 0);
    chk("arst_rd_en", fifo_rd_en, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_valid", m_valid, 0);
    run_basic("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=still running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sfifo_rd_unpack.md
Name: sfifo_rd_unpack

Overview:
- Read-side engine for the team's synchronous FIFO.
- Pops IW-bit words from a FIFO read port (empty / rd_en / show-ahead rd_data) and emits them as RATIO = IW/OW narrow beats on a valid/ready stream.
- Sits between a wide FIFO (e.g. bus-to-peripheral TX buffer) and a narrow consumer such as a byte serializer.
- Never issues a read while the FIFO reports empty.

Parameters:
- IW, 32, FIFO word width in bits.
- OW, 8, output beat width; IW must be an integer multiple of OW, RATIO = IW/OW in 1..16.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous discard of the partially sent word.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_data  in  IW  FIFO head word; valid in the same cycle whenever fifo_empty=0.
- fifo_rd_en  out  1  FIFO pop strobe; combinational.
- m_valid  out  1  output beat valid.
- m_ready  in  1  consumer accept.
- m_data  out  OW  output beat.
- m_last  out  1  current beat is the final slice of its word.
- busy  out  1  a word is held or being unpacked.

Behaviour:
- State: hold_q[IW], cnt[clog2(RATIO) bits, min 1], hold_vld.
- Two states:
  - EMPTY: hold_vld=0.
  - ACTIVE: hold_vld=1.
- Reset values: hold_q=0, cnt=0, hold_vld=0. Therefore m_valid=0, m_last=0 (when RATIO>1), busy=0, m_data=0, and fifo_rd_en=0 while reset_n=0.
- Output mapping: m_valid=hold_vld; busy=hold_vld; m_data=hold_q[cnt*OW +: OW]; m_last = hold_vld & (cnt==RATIO-1).
- Internal term: accept = m_valid & m_ready.
- Pop equation: fifo_rd_en = ~fifo_empty & ~flush & (~hold_vld | (accept & m_last)).
- Pop cycle: hold_q <= fifo_rd_data, cnt <= 0, hold_vld <= 1. Last-beat accept plus a pop in the same cycle gives zero-bubble back-to-back words.
- Accept without last: cnt <= cnt+1.
- Accept on last with no pop (FIFO empty): hold_vld <= 0, cnt <= 0, go to EMPTY.
- Latency: a word visible at cycle N (fifo_empty=0, idle) produces first beat m_valid=1 at cycle N+1. Sustained throughput is 1 beat per clock.
- Stream rule: once m_valid=1, m_data and m_last stay stable until accepted. m_valid never drops without an accept or a flush.
- flush (priority over all else): hold_vld <= 0, cnt <= 0, fifo_rd_en forced 0 that cycle. Remaining beats are lost; the FIFO contents are untouched.
- RATIO=1: m_last is always equal to m_valid; the block degenerates to a one-stage registered pass-through.
- cnt wraps only via reload on pop. It never increments past RATIO-1.
- Reset asserted mid-word: partial word dropped, no pop issued; after release the block is in EMPTY.

Optional Feature:
- Macro SFIFO_RD_UNPACK_MSB_FIRST_EN.
- Defined: beats emitted MSB slice first, m_data = hold_q[(RATIO-1-cnt)*OW +: OW].
- Undefined (default): LSB slice first, as specified above.
- Pop, handshake, m_last and timing are identical in both builds.

Decomposition:
- Package sfifo_pkg holds:
  - the state typedef enum logic {ST_EMPTY, ST_ACTIVE};
  - function clog2_min1(int) for counter widths;
  - elaboration-time check macros shared with the FIFO (IW % OW == 0, RATIO range).
- No sub-module: slice mux and counter stay inline.
- The testbench pairs the block with sync_fifo (W=IW, D=4).

Test Plan:
- IW=32/OW=8, push 0x44332211, m_ready=1 -> m_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles, m_last only on 0x44, exactly one fifo_rd_en pulse.
- Push 0xA0B0C0D0 then 0x01020304 back-to-back, m_ready=1 -> 8 beats on 8 consecutive cycles, no m_valid gap, second fifo_rd_en in the 0xA0 beat cycle.
- m_ready toggling 1,0,0,1,... on 0x44332211 -> m_data held stable while m_ready=0, order preserved, no pop until 0x44 is accepted.
- FIFO empty for 20 cycles with random m_ready -> fifo_rd_en never 1, m_valid 0, no underflow message from the FIFO.
- flush after the 0x22 beat, with 0x88776655 queued -> m_valid=0 next cycle, no pop during flush, then beats 0x55,0x66,0x77,0x88.
- reset_n pulsed low mid-word -> all outputs 0 asynchronously. Rerun the first scenario with SFIFO_RD_UNPACK_MSB_FIRST_EN -> beats 0x44,0x33,0x22,0x11.
